// File: rtl/data_mem_access_unit_if.sv
// data_mem_access_unit_if: CPU request/response channel and data-memory port of the access unit.
interface data_mem_access_unit_if #(parameter int ADDR_W = 11, parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_MemRead;
  logic [DATA_W-1:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_MemRead
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_MemRead
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: byte/half/word loads and stores onto a big-endian word memory with registered read.
// Define MISALIGN_TRAP_EN to reject misaligned half/word requests with resp_err instead of masking the offset.
module data_mem_access_unit #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  data_mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                misal;
  logic [1:0]          req_off;
  logic [4:0]          sh;
  logic [7:0]          byte_l;
  logic [15:0]         half_l;
  logic [DATA_W-1:0]   ext, mask, lane, merged;
`ifdef MISALIGN_TRAP_EN
  assign misal = bus.req_size[1] ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
`else
  assign misal = 1'b0;
`endif
  // offset forced to natural alignment; only matters when misaligned requests are not trapped
  assign req_off = bus.req_size[1] ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~bus.req_size[0]};
  // big-endian: byte at offset k sits 8*(3-k) bits above bit 0, and 3-k == ~k for two bits
  assign sh     = {~off_q, 3'b000};
  assign byte_l = 8'(bus.mem_read_data >> sh);
  assign half_l = off_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
  assign ext    = size_q[1] ? bus.mem_read_data
                : size_q[0] ? {{16{sgn_q & half_l[15]}}, half_l}
                :             {{24{sgn_q & byte_l[7]}}, byte_l};
  assign mask   = size_q[0] ? (off_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000) : 32'h0000_00FF << sh;
  assign lane   = size_q[0] ? {2{wbuf_q[15:0]}} : {4{wbuf_q[7:0]}};
  assign merged = (bus.mem_read_data & ~mask) | (lane & mask);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    write_d = write_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr[ADDR_W-1:2];
        off_d   = req_off;
        size_d  = bus.req_size;
        sgn_d   = bus.req_signed;
        write_d = bus.req_write;
        wbuf_d  = bus.req_wdata;
        valid_d = misal;
        err_d   = misal;
        state_d = misal ? IDLE : (bus.req_write && bus.req_size[1]) ? WRITE : READ;
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        state_d = write_q ? WRITE : IDLE;
        wbuf_d  = write_q ? merged : wbuf_q;
        rdata_d = write_q ? rdata_q : ext;
        valid_d = ~write_q;
      end
      WRITE: begin
        state_d = IDLE;
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      write_q <= 1'b0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      write_q <= write_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  // MemRead derives from the async-reset state so a reset during WRITE cancels the write at once
  assign bus.mem_MemRead    = state_q != WRITE;
  assign bus.mem_address    = {addr_q, 2'b00};
  assign bus.mem_write_data = wbuf_q;
  assign bus.req_ready      = state_q == IDLE;
  assign bus.resp_valid     = valid_q;
  assign bus.resp_err       = err_q;
  assign bus.resp_rdata     = rdata_q;
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed loads/stores against a big-endian word memory model.
module tb_data_mem_access_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          nwr = 0;
  logic [31:0] mem [512];
  data_mem_access_unit_if #(.ADDR_W(11), .DATA_W(32)) bus();
  data_mem_access_unit #(.ADDR_W(11), .DATA_W(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bus.mem_MemRead) bus.mem_read_data <= mem[bus.mem_address[10:2]];
    else begin
      mem[bus.mem_address[10:2]] <= bus.mem_write_data;
      nwr <= nwr + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [10:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.resp_valid && lat < 10);
    if (!bus.resp_valid) lat = 99;
  endtask
  task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic sg, input logic [10:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat, input logic exp_err, input int exp_wr);
    int lat;
    int w0;
    w0 = nwr;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    issue(wr, sz, sg, a, wd);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rd"}, bus.resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, "_wr"}, 32'(nwr - w0), 32'(exp_wr));
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_memread", 32'(bus.mem_MemRead), 32'd1);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_wdata", bus.mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    xfer("st_init", 1, 2'b10, 0, 11'h010, 32'h8899AABB, 32'h00000000, 2, 0, 1);
    xfer("ldb_s11", 0, 2'b00, 1, 11'h011, 32'h0, 32'hFFFFFF99, 3, 0, 0);
    xfer("ldb_u11", 0, 2'b00, 0, 11'h011, 32'h0, 32'h00000099, 3, 0, 0);
    xfer("ldh_u12", 0, 2'b01, 0, 11'h012, 32'h0, 32'h0000AABB, 3, 0, 0);
    xfer("ldh_s12", 0, 2'b01, 1, 11'h012, 32'h0, 32'hFFFFAABB, 3, 0, 0);
    xfer("ldb_s13", 0, 2'b00, 1, 11'h013, 32'h0, 32'hFFFFFFBB, 3, 0, 0);
    xfer("ldh_s10", 0, 2'b01, 1, 11'h010, 32'h0, 32'hFFFF8899, 3, 0, 0);
    xfer("ldb_u10", 0, 2'b00, 0, 11'h010, 32'h0, 32'h00000088, 3, 0, 0);
    xfer("stb_13", 1, 2'b00, 0, 11'h013, 32'h123456CC, 32'h00000088, 4, 0, 1);
    chk("mem_stb_13", mem[4], 32'h8899AACC);
    xfer("sth_10", 1, 2'b01, 0, 11'h010, 32'h00001122, 32'h00000088, 4, 0, 1);
    chk("mem_sth_10", mem[4], 32'h1122AACC);
    xfer("stw_20", 1, 2'b10, 0, 11'h020, 32'hDEADBEEF, 32'h00000088, 2, 0, 1);
    chk("mem_stw_20", mem[8], 32'hDEADBEEF);
    xfer("ldw_20", 0, 2'b10, 0, 11'h020, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    xfer("ldw_10", 0, 2'b11, 0, 11'h010, 32'h0, 32'h1122AACC, 3, 0, 0);
`ifdef MISALIGN_TRAP_EN
    xfer("ldw_22", 0, 2'b10, 0, 11'h022, 32'h0, 32'h1122AACC, 1, 1, 0);
    xfer("ldh_21", 0, 2'b01, 0, 11'h021, 32'h0, 32'h1122AACC, 1, 1, 0);
`else
    xfer("ldw_22", 0, 2'b10, 0, 11'h022, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    xfer("ldh_21", 0, 2'b01, 0, 11'h021, 32'h0, 32'h0000DEAD, 3, 0, 0);
`endif
    xfer("stw_10", 1, 2'b10, 0, 11'h010, 32'h8899AABB, bus.resp_rdata, 2, 0, 1);
    chk("mem_stw_10", mem[4], 32'h8899AABB);
    chk("abort_rdy", 32'(bus.req_ready), 32'd1);
    issue(1, 2'b00, 0, 11'h010, 32'h00000077);
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("abort_in_write", 32'(bus.mem_MemRead), 32'd0);
    chk("abort_waddr", 32'(bus.mem_address), 32'h010);
    chk("abort_wdata", bus.mem_write_data, 32'h7799AABB);
    begin
      int w0;
      w0 = nwr;
      reset_n = 1'b0;
      #1 chk("abort_memread", 32'(bus.mem_MemRead), 32'd1);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) begin
        @(negedge clock);
        chk("abort_novalid", 32'(bus.resp_valid), 32'd0);
      end
      chk("abort_nowrite", 32'(nwr - w0), 32'd0);
    end
    chk("abort_mem", mem[4], 32'h8899AABB);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rdata", bus.resp_rdata, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Load/store initiator between the CPU MEM stage and the byte-addressed, big-endian 2 KB data memory.
- The data memory has one MemRead control: 1 = read, 0 = write, and it acts on every posedge clock with a registered read.
- This block converts CPU byte, halfword and word loads/stores into word-aligned memory accesses. It does read-modify-write for sub-word stores and sign/zero-extends loads.
- It exposes a valid/ready request and one-cycle response handshake to the pipeline.

Parameters:
- ADDR_W, 11, byte-address width; must match the data memory.
- DATA_W, 32, word width; only 32 is supported.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  DATA_W  extended load data; holds its value until the next load response.
- resp_err  out  1  misaligned access, qualified by resp_valid.
- mem_address  out  ADDR_W  address to the data memory.
- mem_write_data  out  DATA_W  write word to the data memory.
- mem_MemRead  out  1  1 = read, 0 = write, to the data memory.
- mem_read_data  in  DATA_W  registered read word from the data memory.

Behaviour:
- Reset (asynchronous, takes effect immediately) forces:
  - state = IDLE;
  - mem_MemRead = 1, mem_address = 0, mem_write_data = 0;
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
- mem_MemRead is 1 in every state except WRITE. The memory writes on any edge where MemRead = 0, so any other value causes spurious writes.
- A request is accepted on a posedge with req_valid & req_ready. At acceptance the unit registers addr, size, signed, write and wdata. Aligned address = addr with bits [1:0] cleared; offset = addr[1:0].
- States:
  - IDLE: waiting for a request.
  - READ: mem_address = aligned address, MemRead = 1.
  - CAPTURE: mem_read_data is valid in this cycle.
  - WRITE: MemRead = 0, mem_address = aligned address, mem_write_data = merged word.
- Transitions:
  - IDLE, on accept: word store goes to WRITE; load or sub-word store goes to READ; misaligned request (see Optional Feature) goes straight back to IDLE with resp_valid = 1 and resp_err = 1 on the next cycle.
  - READ -> CAPTURE, unconditionally.
  - CAPTURE, load: register the extended data into resp_rdata, set resp_valid = 1, go to IDLE.
  - CAPTURE, sub-word store: register the merged word into the write buffer, go to WRITE.
  - WRITE -> IDLE with resp_valid = 1.
- Byte lanes are big-endian:
  - byte at offset k occupies bits [31-8k : 24-8k];
  - half at offset 0 occupies [31:16]; half at offset 2 occupies [15:0].
- Store merge replaces only the addressed lane(s) with req_wdata[7:0] or [15:0]; all other bytes are preserved from mem_read_data.
- Latency from accept edge to resp_valid cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- Each store causes exactly one memory write cycle.
- resp_valid lasts one cycle and is low otherwise. Because the unit is back in IDLE during that cycle, req_ready is high, so back-to-back requests are allowed.
- Reset mid-operation aborts the access. In WRITE, the asynchronous restore of MemRead = 1 prevents the write; memory contents are unchanged and no response is produced.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
- Defined: a misaligned request makes no memory access and returns resp_err = 1 after 1 cycle, with resp_rdata unchanged.
- Undefined: the offset is silently masked to natural alignment (half: clear bit 0; word: clear bits [1:0]), the access proceeds normally, and resp_err is tied to 0.

Test Plan:
- Preload word 0x010 = 0x8899AABB; byte load 0x011, signed -> resp_rdata = 0xFFFFFF99 three cycles after accept; unsigned -> 0x00000099.
- Half load 0x012, unsigned -> 0x0000AABB; signed -> 0xFFFFAABB; mem_MemRead stays 1 throughout.
- Byte store 0x013, wdata 0x123456CC -> word 0x010 becomes 0x8899AACC; exactly one MemRead = 0 cycle; resp_valid 4 cycles after accept.
- Word store 0x020 = 0xDEADBEEF, then back-to-back word load 0x020 -> 0xDEADBEEF; second request accepted in the store's resp_valid cycle.
- Word load 0x022: with MISALIGN_TRAP_EN -> resp_err = 1 after 1 cycle and no memory access; without it -> returns the word at 0x020, resp_err = 0.
- Assert reset_n low during WRITE of a byte store to 0x010 -> word remains 0x8899AABB, resp_valid = 0, req_ready = 1 after release.
